// File: rtl/sfx_synth.sv
// sfx_synth: single-voice sound-effect generator (square/noise) feeding the PWM duty input.
// Define SFX_DECAY_EN to make non-ufo effects lose one volume step every 256 ticks.
module sfx_synth #(
  parameter int DUTY_WIDTH = 8,
  parameter int SAMPLE_DIV = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            trig,
  input  logic                  mute,
  output logic [DUTY_WIDTH-1:0] duty,
  output logic                  busy,
  output logic [1:0]            active_sfx
);

  localparam int DW = $clog2(SAMPLE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  localparam logic [1:0] SHOOT = 2'd0;
  localparam logic [1:0] EXPL  = 2'd1;
  localparam logic [1:0] STEP  = 2'd2;
  localparam logic [1:0] UFO   = 2'd3;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t state, state_n;

  logic [DW-1:0] div;
  logic          tick;
  logic          armed;
  logic [2:0]    prev, pending, edges;

  logic [1:0]  cur, cur_n, sel, start_sfx;
  logic [7:0]  hp, hp_n, phase, phase_n;
  logic        wave, wave_n;
  logic [12:0] len, len_n;
  logic [3:0]  vol, vol_n;
  logic [5:0]  sweep, sweep_n;
  logic [14:0] lfsr, lfsr_n;
  logic [DUTY_WIDTH-1:0] duty_n;

  logic ufo_req, hit_exp, hit_sht, hit_ufo, hit_stp;
  logic req, accept, ending, resume, start;

`ifdef SFX_DECAY_EN
  logic [7:0] decay, decay_n;
`endif

  function automatic logic [1:0] rank(input logic [1:0] s);
    unique case (s)
      EXPL:    rank = 2'd3;
      SHOOT:   rank = 2'd2;
      UFO:     rank = 2'd1;
      default: rank = 2'd0;
    endcase
  endfunction

  assign tick  = (div == DIV_LAST);
  // First clk after reset only primes prev, so levels held through reset are not edges
  assign edges = armed ? (trig[2:0] & ~prev) : 3'b000;

  assign ufo_req = trig[3] & ~(state == PLAY && cur == UFO);
  assign hit_exp = pending[1];
  assign hit_sht = pending[0] & ~pending[1];
  assign hit_ufo = ufo_req & ~pending[1] & ~pending[0];
  assign hit_stp = pending[2] & ~pending[1] & ~pending[0] & ~ufo_req;

  always_comb begin
    req = 1'b0;
    sel = STEP;
    unique case (1'b1)
      hit_exp: begin req = 1'b1; sel = EXPL;  end
      hit_sht: begin req = 1'b1; sel = SHOOT; end
      hit_ufo: begin req = 1'b1; sel = UFO;   end
      hit_stp: begin req = 1'b1; sel = STEP;  end
      default: ;
    endcase
  end

  assign accept = req && (state == IDLE || rank(sel) >= rank(cur));
  assign ending = (state == PLAY) &&
                  ((cur == UFO) ? !trig[3] : (len == 13'd1));
  assign resume = ending && (cur != UFO) && trig[3];
  assign start  = accept || resume;
  assign start_sfx = accept ? sel : UFO;

  always_comb begin
    state_n = state;
    cur_n   = cur;
    hp_n    = hp;
    phase_n = phase;
    wave_n  = wave;
    len_n   = len;
    vol_n   = vol;
    sweep_n = sweep;
    lfsr_n  = lfsr;
`ifdef SFX_DECAY_EN
    decay_n = decay;
`endif
    if (start) begin
      state_n = PLAY;
      cur_n   = start_sfx;
      wave_n  = 1'b1;
      sweep_n = '0;
`ifdef SFX_DECAY_EN
      decay_n = '0;
`endif
      unique case (start_sfx)
        SHOOT:   begin hp_n = 8'd4;  len_n = 13'd2048; vol_n = 4'd15; end
        EXPL:    begin hp_n = 8'd2;  len_n = 13'd4096; vol_n = 4'd15; end
        STEP:    begin hp_n = 8'd24; len_n = 13'd512;  vol_n = 4'd12; end
        default: begin hp_n = 8'd10; len_n = 13'd0;    vol_n = 4'd8;  end
      endcase
      phase_n = hp_n;
    end else if (ending) begin
      state_n = IDLE;
    end else if (state == PLAY) begin
      sweep_n = sweep + 6'd1;
      if (cur == SHOOT && sweep_n == 6'd0 && hp != 8'hFF)
        hp_n = hp + 8'd1;
`ifdef SFX_DECAY_EN
      decay_n = decay + 8'd1;
      if (cur != UFO && decay_n == 8'd0 && vol != 4'd0)
        vol_n = vol - 4'd1;
`endif
      if (phase == 8'd1) begin
        phase_n = hp_n;
        if (cur == EXPL) begin
          lfsr_n = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
          wave_n = lfsr_n[0];
        end else begin
          wave_n = ~wave;
        end
      end else begin
        phase_n = phase - 8'd1;
      end
      if (cur != UFO)
        len_n = len - 13'd1;
    end
    duty_n = '0;
    if (state_n == PLAY && wave_n && !mute)
      duty_n = DUTY_WIDTH'(vol_n) << (DUTY_WIDTH - 4);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div     <= '0;
      armed   <= 1'b0;
      prev    <= '0;
      pending <= '0;
      state   <= IDLE;
      cur     <= SHOOT;
      hp      <= '0;
      phase   <= '0;
      wave    <= 1'b0;
      len     <= '0;
      vol     <= '0;
      sweep   <= '0;
      lfsr    <= 15'h0001;
      duty    <= '0;
`ifdef SFX_DECAY_EN
      decay   <= '0;
`endif
    end else begin
      div     <= tick ? '0 : div + DW'(1);
      armed   <= 1'b1;
      prev    <= trig[2:0];
      pending <= tick ? edges : (pending | edges);
      if (tick) begin
        state <= state_n;
        cur   <= cur_n;
        hp    <= hp_n;
        phase <= phase_n;
        wave  <= wave_n;
        len   <= len_n;
        vol   <= vol_n;
        sweep <= sweep_n;
        lfsr  <= lfsr_n;
        duty  <= duty_n;
`ifdef SFX_DECAY_EN
        decay <= decay_n;
`endif
      end
    end
  end

  assign busy       = (state == PLAY);
  assign active_sfx = busy ? cur : 2'd0;

endmodule
